// File: rtl/lmsm_sequencer_pkg.sv
// lmsm_sequencer shared types and constants.
// LM/SM opcodes, list width and the NOP image.
package lmsm_sequencer_pkg;

  localparam logic [3:0]  OPC_LM = 4'b0110;
  localparam logic [3:0]  OPC_SM = 4'b0111;
  localparam logic [15:0] NOP_IR = 16'hF000;
  localparam int          LIST_W = 8;
  localparam int          IDX_W  = $clog2(LIST_W);

  typedef enum logic {
    IDLE,
    SEQ
  } seqState_t;

  function automatic logic [LIST_W-1:0] clearLowest(
    input logic [LIST_W-1:0] m
  );
    return m & (m - LIST_W'(1));
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Decode-side bundle between the IF/ID register
// and the ID/RR register for the LM/SM sequencer.
interface lmsm_sequencer_if;
  import lmsm_sequencer_pkg::*;

  logic [15:0]      ir;
  logic             ir_valid;
  logic             stall;
  logic             flush;
  logic             modify_ir;
  logic [IDX_W-1:0] modify_pr2_ra;
  logic             first_multiple;
  logic             last_multiple;
  logic [IDX_W-1:0] mem_offset;
  logic             hold_fetch;
  logic             insert_nop;

  modport master (
    output ir, ir_valid, stall, flush,
    input  modify_ir, modify_pr2_ra,
    input  first_multiple, last_multiple,
    input  mem_offset, hold_fetch, insert_nop
  );

  modport slave (
    input  ir, ir_valid, stall, flush,
    output modify_ir, modify_pr2_ra,
    output first_multiple, last_multiple,
    output mem_offset, hold_fetch, insert_nop
  );

endinterface

// File: rtl/lmsm_sequencer_lsb_priority_enc8.sv
// Lowest-set-bit encoder for an 8-bit list.
// Also flags empty and single-bit masks.
module lsb_priority_enc8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any,
  output logic       oneHotOnly
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign any        = |mask;
  assign oneHotOnly = any & ~|(mask & (mask - 8'd1));

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op generator in the decode stage.
// One micro-op per set list bit, ascending order.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  lmsm_sequencer_if.slave bus
);

  seqState_t         state;
  logic [LIST_W-1:0] remMask;
  logic [IDX_W-1:0]  cnt;

  logic [LIST_W-1:0] curMask;
  logic [IDX_W-1:0]  curIdx;
  logic              curAny;
  logic              curOne;
  logic              isMult;
  logic              isIdle;
  logic              active;
  logic              unusedIrBits;

  assign unusedIrBits = ^bus.ir[11:8];

  assign isIdle  = (state == IDLE);
  assign isMult  = bus.ir_valid &
                   ((bus.ir[15:12] == OPC_LM) |
                    (bus.ir[15:12] == OPC_SM));
  assign curMask = isIdle ? bus.ir[LIST_W-1:0]
                          : remMask;

  lsb_priority_enc8 uEnc (
    .mask       (curMask),
    .idx        (curIdx),
    .any        (curAny),
    .oneHotOnly (curOne)
  );

  assign active = ~isIdle | (isMult & curAny);

  // decode outputs; flush blanks the whole cycle
  always_comb begin
    bus.modify_ir      = 1'b0;
    bus.modify_pr2_ra  = '0;
    bus.first_multiple = 1'b0;
    bus.last_multiple  = 1'b0;
    bus.mem_offset     = '0;
    bus.hold_fetch     = 1'b0;
    bus.insert_nop     = 1'b0;
    if (!bus.flush) begin
      if (active) begin
        bus.modify_ir      = 1'b1;
        bus.modify_pr2_ra  = curIdx;
        bus.first_multiple = isIdle;
        bus.last_multiple  = curOne;
        bus.mem_offset     = isIdle ? '0 : cnt;
        bus.hold_fetch     = ~curOne;
      end else if (isIdle & isMult) begin
        bus.insert_nop     = 1'b1;
      end
    end
  end

  // sequence state; flush beats stall beats advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      remMask <= '0;
      cnt     <= '0;
    end else if (bus.flush) begin
      state   <= IDLE;
      remMask <= '0;
      cnt     <= '0;
    end else if (!bus.stall) begin
      unique case (state)
        IDLE: begin
          if (isMult & curAny & ~curOne) begin
            state   <= SEQ;
            remMask <= clearLowest(curMask);
            cnt     <= IDX_W'(1);
          end
        end
        SEQ: begin
          if (curOne) begin
            state   <= IDLE;
            remMask <= '0;
            cnt     <= '0;
          end else begin
            remMask <= clearLowest(remMask);
            cnt     <= cnt + IDX_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          remMask <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: queue model plus
// directed vectors with literal expectations.
module tb_lmsm_sequencer;
  import lmsm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   asserts = 0;
  int   fails = 0;

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] dutOut;
  assign dutOut = {bus.modify_ir, bus.modify_pr2_ra,
                   bus.first_multiple, bus.last_multiple,
                   bus.mem_offset, bus.hold_fetch,
                   bus.insert_nop};

  function automatic logic [10:0] P(
    input logic m, input logic [2:0] ra,
    input logic f, input logic l,
    input logic [2:0] off, input logic h,
    input logic n
  );
    return {m, ra, f, l, off, h, n};
  endfunction

  // model: pending registers of the running sequence
  int q[$];
  int pos = 0;

  function automatic void regList(
    input logic [15:0] i, output int l[$]
  );
    l = {};
    for (int b = 0; b < 8; b++)
      if (i[b]) l.push_back(b);
  endfunction

  function automatic logic isMultM();
    return bus.ir_valid &&
      (bus.ir[15:12] == 4'h6 || bus.ir[15:12] == 4'h7);
  endfunction

  function automatic logic [10:0] modelOut();
    int l[$];
    if (bus.flush) return '0;
    if (q.size() == 0) begin
      if (!isMultM()) return '0;
      regList(bus.ir, l);
      if (l.size() == 0) return P(0,0,0,0,0,0,1);
      return P(1, 3'(l[0]), 1, l.size() == 1, 0,
               l.size() > 1, 0);
    end
    return P(1, 3'(q[0]), 0, q.size() == 1, 3'(pos),
             q.size() > 1, 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    int l[$];
    if (!reset) begin
      q = {};
      pos = 0;
    end else if (bus.flush) begin
      q = {};
      pos = 0;
    end else if (!bus.stall) begin
      if (q.size() == 0) begin
        if (isMultM()) begin
          regList(bus.ir, l);
          if (l.size() > 1) begin
            void'(l.pop_front());
            q = l;
            pos = 1;
          end
        end
      end else begin
        void'(q.pop_front());
        pos++;
        if (q.size() == 0) pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    e = modelOut();
    asserts++;
    if (dutOut !== e) begin
      fails++;
      $display("FAIL model t=%0t got=%b exp=%b",
               $time, dutOut, e);
    end
  end

  task automatic cyc(
    input string nm, input logic [15:0] i,
    input logic v, input logic s, input logic f,
    input logic r, input logic [10:0] exp
  );
    bus.ir = i;
    bus.ir_valid = v;
    bus.stall = s;
    bus.flush = f;
    reset = r;
    @(negedge clk);
    #1;
    asserts++;
    if (dutOut !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", nm, dutOut, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ir = NOP_IR;
    bus.ir_valid = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    cyc("rst", 16'h60A5, 1, 0, 0, 0, P(1,0,1,0,0,1,0));
    cyc("rst2", NOP_IR, 0, 0, 0, 0, '0);
    cyc("bubble", NOP_IR, 0, 0, 0, 1, '0);
    cyc("lm0", 16'h60A5, 1, 0, 0, 1, P(1,0,1,0,0,1,0));
    cyc("lm1", 16'h60A5, 1, 0, 0, 1, P(1,2,0,0,1,1,0));
    cyc("lm2", 16'h60A5, 1, 0, 0, 1, P(1,5,0,0,2,1,0));
    cyc("lm3", 16'h60A5, 1, 0, 0, 1, P(1,7,0,1,3,0,0));
    cyc("lmIdle", NOP_IR, 0, 0, 0, 1, '0);
    cyc("sm1", 16'h7010, 1, 0, 0, 1, P(1,4,1,1,0,0,0));
    cyc("sm1b", 16'h7080, 1, 0, 0, 1, P(1,7,1,1,0,0,0));
    cyc("nop", 16'h6000, 1, 0, 0, 1, P(0,0,0,0,0,0,1));
    cyc("alu", 16'h1234, 1, 0, 0, 1, '0);
    cyc("ff0", 16'h70FF, 1, 0, 0, 1, P(1,0,1,0,0,1,0));
    cyc("ff1", 16'h70FF, 1, 0, 0, 1, P(1,1,0,0,1,1,0));
    cyc("ffS1", 16'h70FF, 1, 1, 0, 1, P(1,2,0,0,2,1,0));
    cyc("ffS2", 16'h70FF, 1, 1, 0, 1, P(1,2,0,0,2,1,0));
    cyc("ff2", 16'h70FF, 1, 0, 0, 1, P(1,2,0,0,2,1,0));
    for (int k = 3; k < 7; k++)
      cyc("ffk", 16'h70FF, 1, 0, 0, 1,
          P(1, 3'(k), 0, 0, 3'(k), 1, 0));
    cyc("ff7", 16'h70FF, 1, 0, 0, 1, P(1,7,0,1,7,0,0));
    cyc("fl0", 16'h6066, 1, 0, 0, 1, P(1,1,1,0,0,1,0));
    cyc("fl1", 16'h6066, 1, 0, 1, 1, '0);
    cyc("add", 16'h0000, 1, 0, 0, 1, '0);
    cyc("sf", 16'h6003, 1, 1, 1, 1, '0);
    cyc("is0", 16'h6003, 1, 1, 0, 1, P(1,0,1,0,0,1,0));
    cyc("is1", 16'h6003, 1, 0, 0, 1, P(1,0,1,0,0,1,0));
    cyc("is2", 16'h6003, 1, 0, 0, 1, P(1,1,0,1,1,0,0));
    cyc("rs0", 16'h60FF, 1, 0, 0, 1, P(1,0,1,0,0,1,0));
    cyc("rs1", 16'h60FF, 1, 0, 0, 1, P(1,1,0,0,1,1,0));
    cyc("rsMid", 16'h60FF, 1, 0, 0, 0, P(1,0,1,0,0,1,0));
    cyc("rsRel", NOP_IR, 0, 0, 0, 1, '0);
    cyc("rsNew", 16'h7003, 1, 0, 0, 1, P(1,0,1,0,0,1,0));
    cyc("rsNew1", 16'h7003, 1, 0, 0, 1, P(1,1,0,1,1,0,0));
    cyc("end", NOP_IR, 0, 0, 0, 1, '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
